// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle signed/unsigned adder-subtractor.
//
// A WIDTH-bit add or subtract is computed in SLICE-bit ripple slices,
// one slice per clock. A carry register links the slices. On an accepted
// operation the block takes N = WIDTH/SLICE compute cycles. The result is
// then held until the consumer takes it.
//
// Optional build macro:
//   ADDSUB_SAT_EN - on signed overflow the final sum is replaced by the
//                   signed saturation value. ovf and c_out still report
//                   the raw result.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and mode valid
//   in_ready   block can accept an operation (IDLE)
//   A, B       WIDTH-bit operands
//   mode       0 = A+B, 1 = A-B
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   sum        WIDTH-bit result
//   c_out      carry out of the MSB (for subtract, 1 = no borrow)
//   ovf        two's-complement overflow
module seq_addsub #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE:0]   sl_full;
    logic [SLICE-1:0] sl_sum;
    logic             sl_cout;
    logic             sl_ovf;
    logic             last;
    logic [WIDTH-1:0] sum_shift;

    // The operand registers shift right one slice per CALC cycle, so the
    // active slice is always in the low bits. The result shifts in from the
    // top, and after N cycles it lands in place. This avoids a
    // counter-indexed part-select.
    always_comb begin
        sl_a      = a_reg[SLICE-1:0];
        sl_b      = b_reg[SLICE-1:0];
        sl_full   = {1'b0, sl_a} + {1'b0, sl_b} + {{SLICE{1'b0}}, carry};
        sl_sum    = sl_full[SLICE-1:0];
        sl_cout   = sl_full[SLICE];
        // Carry into the MSB is a^b^s at that bit. ovf = carry_in ^ carry_out.
        sl_ovf    = sl_a[SLICE-1] ^ sl_b[SLICE-1] ^ sl_sum[SLICE-1] ^ sl_cout;
        sum_shift = (WIDTH'(sl_sum) << (WIDTH - SLICE)) | (sum >> SLICE);
        last      = (cnt == LAST);
    end

`ifdef ADDSUB_SAT_EN
    logic [WIDTH-1:0] sat_val;

    // On the final slice, sl_a[SLICE-1] is the sign bit of A.
    always_comb begin
        sat_val = sl_a[SLICE-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= A;
                        b_reg <= mode ? ~B : B;
                        carry <= mode;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    a_reg <= a_reg >> SLICE;
                    b_reg <= b_reg >> SLICE;
                    carry <= sl_cout;
                    sum   <= sum_shift;
                    if (last) begin
                        cnt   <= '0;
                        c_out <= sl_cout;
                        ovf   <= sl_ovf;
`ifdef ADDSUB_SAT_EN
                        if (sl_ovf) sum <= sat_val;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
module tb_seq_addsub;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Instance 0: WIDTH=16/SLICE=4.
    // Instance 1: WIDTH=8/SLICE=8.
    // Instance 2: WIDTH=32/SLICE=1.
    int W  [3] = '{16, 8, 32};
    int NS [3] = '{4, 1, 32};

    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] a_in      [3];
    logic [31:0] b_in      [3];
    logic        mode_in   [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic        c_out     [3];
    logic        ovf       [3];
    logic [15:0] sum0;
    logic [7:0]  sum1;
    logic [31:0] sum2;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] last_sum;
    logic        last_c;
    logic        last_v;

    seq_addsub #(.WIDTH(16), .SLICE(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .A(a_in[0][15:0]), .B(b_in[0][15:0]), .mode(mode_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum0), .c_out(c_out[0]), .ovf(ovf[0])
    );

    seq_addsub #(.WIDTH(8), .SLICE(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .A(a_in[1][7:0]), .B(b_in[1][7:0]), .mode(mode_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum1), .c_out(c_out[1]), .ovf(ovf[1])
    );

    seq_addsub #(.WIDTH(32), .SLICE(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .A(a_in[2]), .B(b_in[2]), .mode(mode_in[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum2), .c_out(c_out[2]), .ovf(ovf[2])
    );

    function automatic logic [63:0] get_sum(input int k);
        case (k)
            0:       return 64'(sum0);
            1:       return 64'(sum1);
            default: return 64'(sum2);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: signed/unsigned interpretation with plain integer arithmetic.
    task automatic model(input int w, input longint a, input longint b, input bit m,
                         output longint s, output bit c, output bit v);
        longint md, half, sa, sb, r;
        md   = longint'(1) << w;
        half = md / 2;
        sa   = (a >= half) ? a - md : a;
        sb   = (b >= half) ? b - md : b;
        r    = m ? sa - sb : sa + sb;
        v    = (r >= half) || (r < -half);
        c    = m ? (a >= b) : ((a + b) >= md);
        s    = (m ? a - b : a + b) & (md - 1);
`ifdef ADDSUB_SAT_EN
        if (v) s = (sa >= 0) ? half - 1 : half;
`endif
    endtask

    function automatic longint pick(input int w);
        longint md;
        md = longint'(1) << w;
        case ($urandom % 8)
            0:       return 0;
            1:       return md - 1;
            2:       return md / 2;
            3:       return md / 2 - 1;
            default: return longint'($urandom) & (md - 1);
        endcase
    endfunction

    // Called at a negedge. Returns at the negedge after the accept edge.
    // By then the operands have already been scrambled.
    task automatic start_op(input int k, input longint a, input longint b, input bit m);
        int t;
        t = 0;
        while (!in_ready[k] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready[k]) begin
            check($sformatf("d%0d_ready_timeout", k), 64'(in_ready[k]), 64'd1);
            return;
        end
        a_in[k]     = 32'(a);
        b_in[k]     = 32'(b);
        mode_in[k]  = m;
        in_valid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        a_in[k]     = $urandom;
        b_in[k]     = $urandom;
        mode_in[k]  = 1'($urandom);
    endtask

    task automatic finish_op(input int k, input longint a, input longint b, input bit m,
                             input bit release_out);
        int     lat;
        longint es;
        bit     ec, ev;
        lat = 0;
        while (!out_valid[k] && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check($sformatf("d%0d_latency", k), 64'(lat), 64'(NS[k]));
        model(W[k], a, b, m, es, ec, ev);
        last_sum = get_sum(k);
        last_c   = c_out[k];
        last_v   = ovf[k];
        check($sformatf("d%0d_sum a=%0h b=%0h m=%0d", k, a, b, m), last_sum, 64'(es));
        check($sformatf("d%0d_cout a=%0h b=%0h m=%0d", k, a, b, m), 64'(last_c), 64'(ec));
        check($sformatf("d%0d_ovf a=%0h b=%0h m=%0d", k, a, b, m), 64'(last_v), 64'(ev));
        if (release_out) begin
            out_ready[k] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("d%0d_valid_drop", k), 64'(out_valid[k]), 64'd0);
            check($sformatf("d%0d_ready_back", k), 64'(in_ready[k]), 64'd1);
        end
    endtask

    task automatic do_op(input int k, input longint a, input longint b, input bit m);
        start_op(k, a, b, m);
        finish_op(k, a, b, m, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint es;
        bit     ec, ev;
        bit     seen;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            a_in[k]      = '0;
            b_in[k]      = '0;
            mode_in[k]   = 1'b0;
            out_ready[k] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("d%0d_rst_in_ready", k), 64'(in_ready[k]), 64'd1);
            check($sformatf("d%0d_rst_out_valid", k), 64'(out_valid[k]), 64'd0);
            check($sformatf("d%0d_rst_sum", k), get_sum(k), 64'd0);
            check($sformatf("d%0d_rst_cout", k), 64'(c_out[k]), 64'd0);
            check($sformatf("d%0d_rst_ovf", k), 64'(ovf[k]), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors on the 16/4 instance.
        do_op(0, 'h1234, 'h0FFF, 1'b0);
        check("t1_sum", last_sum, 64'h2233);
        check("t1_cout", 64'(last_c), 64'd0);
        check("t1_ovf", 64'(last_v), 64'd0);

        do_op(0, 'h0005, 'h0007, 1'b1);
        check("t2a_sum", last_sum, 64'hFFFE);
        check("t2a_cout", 64'(last_c), 64'd0);
        check("t2a_ovf", 64'(last_v), 64'd0);

        do_op(0, 'h0007, 'h0005, 1'b1);
        check("t2b_sum", last_sum, 64'h0002);
        check("t2b_cout", 64'(last_c), 64'd1);

        do_op(0, 'h7FFF, 'h0001, 1'b0);
`ifdef ADDSUB_SAT_EN
        check("t3a_sum", last_sum, 64'h7FFF);
`else
        check("t3a_sum", last_sum, 64'h8000);
`endif
        check("t3a_ovf", 64'(last_v), 64'd1);
        check("t3a_cout", 64'(last_c), 64'd0);

        do_op(0, 'h8000, 'h0001, 1'b1);
`ifdef ADDSUB_SAT_EN
        check("t3b_sum", last_sum, 64'h8000);
`else
        check("t3b_sum", last_sum, 64'h7FFF);
`endif
        check("t3b_ovf", 64'(last_v), 64'd1);

        do_op(0, 'hFFFF, 'h0001, 1'b0);
        check("t3c_sum", last_sum, 64'h0000);
        check("t3c_cout", 64'(last_c), 64'd1);
        check("t3c_ovf", 64'(last_v), 64'd0);

        // Backpressure: the result must hold while new requests are ignored.
        out_ready[0] = 1'b0;
        start_op(0, 'h4321, 'h1111, 1'b0);
        finish_op(0, 'h4321, 'h1111, 1'b0, 1'b0);
        model(16, 'h4321, 'h1111, 1'b0, es, ec, ev);
        for (int i = 0; i < 3; i++) begin
            a_in[0]     = $urandom;
            b_in[0]     = $urandom;
            mode_in[0]  = 1'($urandom);
            in_valid[0] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp%0d_sum", i), get_sum(0), 64'(es));
            check($sformatf("bp%0d_cout", i), 64'(c_out[0]), 64'(ec));
            check($sformatf("bp%0d_ovf", i), 64'(ovf[0]), 64'(ev));
            check($sformatf("bp%0d_valid", i), 64'(out_valid[0]), 64'd1);
            check($sformatf("bp%0d_in_ready", i), 64'(in_ready[0]), 64'd0);
        end
        a_in[0]      = 32'h0F0F;
        b_in[0]      = 32'h00F1;
        mode_in[0]   = 1'b1;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready[0]), 64'd1);
        check("bp_release_valid", 64'(out_valid[0]), 64'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        a_in[0]     = $urandom;
        b_in[0]     = $urandom;
        finish_op(0, 'h0F0F, 'h00F1, 1'b1, 1'b1);
        check("bp_new_sum", last_sum, 64'h0E1E);

        // Reset in the middle of CALC.
        start_op(0, 'hAAAA, 'h5555, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_in_ready", 64'(in_ready[0]), 64'd1);
        check("mr_out_valid", 64'(out_valid[0]), 64'd0);
        check("mr_sum", get_sum(0), 64'd0);
        check("mr_cout", 64'(c_out[0]), 64'd0);
        check("mr_ovf", 64'(ovf[0]), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        check("mr_no_spurious_valid", 64'(seen), 64'd0);
        do_op(0, 'h0001, 'h0001, 1'b0);
        check("mr_next_sum", last_sum, 64'h0002);

        // Randomized sweep on all three configurations.
        for (int i = 0; i < 100; i++) do_op(0, pick(16), pick(16), 1'($urandom));
        for (int i = 0; i < 200; i++) do_op(1, pick(8), pick(8), 1'($urandom));
        for (int i = 0; i < 200; i++) do_op(2, pick(32), pick(32), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised, multi-cycle signed/unsigned adder-subtractor; successor to the team's 8-bit combinational ripple-carry `adder` (A, B, mode, sum, c_out).
- Processes a WIDTH-bit operation in SLICE-bit ripple slices, one slice per clock, with a stored carry between slices.
- Valid/ready handshakes on input and output, plus an `ovf` signed-overflow flag.
- Sits between operand registers and the datapath result bus; trades latency for a short critical path.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits computed per cycle; 1 <= SLICE <= WIDTH.
- N (localparam) = WIDTH/SLICE, number of compute cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept an operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- mode  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of MSB. For subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, ovf=0, slice counter=0, carry=0. All internal operand registers are cleared.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, latch A, latch B (or ~B when mode=1), latch carry=mode, go to CALC. A, B and mode may change after the accept edge.
  - CALC: in_ready=0. Each edge computes slice i (bits i*SLICE+SLICE-1 .. i*SLICE) from the latched operands and the stored carry. It writes that slice of sum, stores the slice carry-out, and increments i.
  - CALC exit: on the edge that completes slice N-1, register c_out, register ovf = (carry into MSB) XOR (carry out of MSB), go to DONE.
  - DONE: out_valid=1. sum, c_out and ovf are held stable until out_valid && out_ready. On that edge go to IDLE and set out_valid=0.
- Latency: out_valid is high after exactly N rising edges following the accept edge. Throughput is one operation per N+2 cycles when out_ready is held high.
- Partial results: sum bits of unfinished slices are unspecified while in CALC. Only DONE values are architectural.
- in_valid in CALC or DONE is ignored. Producer must hold its request until in_ready.
- out_ready while not in DONE is ignored.
- Reset mid-operation: operation is discarded, outputs return to reset values immediately, and no spurious out_valid follows.
- Arithmetic is modulo 2^WIDTH. c_out is the carry out of the full-width sum. ovf uses the signed interpretation of A and B.
- N=1 (SLICE=WIDTH) is legal: a single CALC cycle.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: when ovf=1, sum in DONE is replaced by signed saturation. Result is 2^(WIDTH-1)-1 if A is non-negative, else -2^(WIDTH-1). ovf and c_out still report raw values. The replacement adds no cycle; it is applied on the final CALC edge.
- Undefined: sum is always the wrapped modulo result. No saturation logic is present.

Test Plan (WIDTH=16, SLICE=4 unless noted):
1. Add: A=0x1234, B=0x0FFF, mode=0 -> sum=0x2233, c_out=0, ovf=0. out_valid rises exactly 4 edges after accept.
2. Subtract with borrow: A=0x0005, B=0x0007, mode=1 -> sum=0xFFFE, c_out=0, ovf=0. A=0x0007, B=0x0005 -> sum=0x0002, c_out=1.
3. Overflow:
   - A=0x7FFF+B=0x0001 -> sum=0x8000 (0x7FFF with ADDSUB_SAT_EN), ovf=1, c_out=0.
   - A=0x8000-B=0x0001 -> sum=0x7FFF (0x8000 with ADDSUB_SAT_EN), ovf=1.
   - A=0xFFFF+B=0x0001 -> sum=0x0000, c_out=1, ovf=0.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands -> sum/flags unchanged, in_ready=0, new operands not taken. Release out_ready -> in_ready=1 next cycle, then the new op completes correctly.
5. Reset mid-CALC: assert rst_n=0 after 2 CALC edges -> outputs immediately at reset values, in_ready=1, no out_valid after release. Next op 0x0001+0x0001 -> 0x0002.
6. Parameter sweep: WIDTH=8/SLICE=8 and WIDTH=32/SLICE=1, 200 random ops each vs. reference model -> all match. Latency is 1 and 32 edges respectively.
